// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that
// issues md-class instructions into it.
package mdu_pkg;

    // Operation codes carried on md_op; the decoder uses the same encoding.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // IDLE: no operation in flight. RUN: counting down an operation's latency.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Default latencies, in busy cycles.
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    // True for the four operations that occupy the unit for several cycles.
    function automatic logic is_md_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the two divide operations.
    function automatic logic is_md_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: signed/unsigned 32x32 multiply and divide.
// The result is computed in one shot; the surrounding unit only models
// the latency.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_by_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_rt_zero;
    logic               w_div_ovf;
    logic        [31:0] w_den_s;
    logic        [31:0] w_den_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    assign w_rt_zero = (i_rt == 32'd0);
    // INT_MIN / -1 overflows; dividing by +1 instead yields exactly the
    // wrapped architectural answer (quotient INT_MIN, remainder 0).
    assign w_div_ovf = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

    // A zero divisor is replaced by 1 so the divider never produces X; the
    // result is discarded via o_div_by_zero anyway.
    assign w_den_s = (w_rt_zero || w_div_ovf) ? 32'd1 : i_rt;
    assign w_den_u = w_rt_zero ? 32'd1 : i_rt;

    assign w_quo_s = $signed(i_rs) / $signed(w_den_s);
    assign w_rem_s = $signed(i_rs) % $signed(w_den_s);
    assign w_quo_u = i_rs / w_den_u;
    assign w_rem_u = i_rs % w_den_u;

    // Select the result pair for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        o_hi          = '0;
        o_lo          = '0;
        o_div_by_zero = 1'b0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                o_hi          = w_rem_s;
                o_lo          = w_quo_s;
                o_div_by_zero = w_rt_zero;
            end
            MD_DIVU: begin
                o_hi          = w_rem_u;
                o_lo          = w_quo_u;
                o_div_by_zero = w_rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit beside the E-stage ALU. Owns the
// architectural HI/LO registers and reports busy/pending to the stall unit.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        md_pending,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    md_op_e      w_op;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_by_zero;

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_commit;

    assign w_op = md_op_e'(md_op);

    mdu_arith u_arith (
        .i_op          (w_op),
        .i_rs          (rs_data),
        .i_rt          (rt_data),
        .o_hi          (w_res_hi),
        .o_lo          (w_res_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    // FSM: accept ops in IDLE, count the latency in RUN, commit HI/LO at the end.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_pend_hi     <= '0;
            r_pend_lo     <= '0;
            r_pend_commit <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_md_arith(w_op)) begin
                            r_pend_hi     <= w_res_hi;
                            r_pend_lo     <= w_res_lo;
                            // A divide by zero still runs full length but leaves HI/LO alone.
                            r_pend_commit <= !w_div_by_zero;
                            r_cnt         <= is_md_div(w_op) ? CNT_W'(DIV_CYCLES)
                                                             : CNT_W'(MULT_CYCLES);
                            r_state       <= ST_RUN;
                        end else if (w_op == MD_MTHI) begin
                            r_hi <= rs_data;
                        end else if (w_op == MD_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored here: the stall unit never issues into a busy unit.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        if (r_pend_commit) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign md_pending = start | busy;
    assign hi_out     = r_hi;
    assign lo_out     = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pairs are queued
// when an operation is issued and compared when busy falls.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        md_pending;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];
    logic [63:0] shadow;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .busy       (busy),
        .md_pending (md_pending),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} after the operation, given the current pair.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return sa * sb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return cur;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    // Issue a mult/div, optionally injecting a second start mid-flight, then
    // measure the busy window and compare the committed HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles, input logic [2:0] inj_op);
        int cnt;
        @(negedge clk);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        sb_q.push_back(model(op, a, b, shadow));
        #1;
        check({tag, "_pend_start"}, 64'(md_pending), 64'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        cnt   = 0;
        while (busy && cnt < 40) begin
            check({tag, "_pend_busy"}, 64'(md_pending), 64'd1);
            cnt++;
            if (cnt == 2 && inj_op != 3'd0) begin
                start   = 1'b1;
                md_op   = inj_op;
                rs_data = 32'h0000_5555;
                rt_data = 32'h0000_0003;
            end else begin
                start = 1'b0;
                md_op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_op = 3'd0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(exp_cycles));
        shadow = sb_q.pop_front();
        check({tag, "_hilo"}, {hi_out, lo_out}, shadow);
    endtask

    // MTHI / MTLO in IDLE: single-cycle write, busy stays low.
    task automatic write_hilo(input string tag, input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        start   = 1'b1;
        md_op   = op;
        rs_data = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        if (op == 3'd5) shadow[63:32] = v;
        else            shadow[31:0]  = v;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hilo"}, {hi_out, lo_out}, shadow);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          cnt;

        reset   = 1'b1;
        start   = 1'b0;
        md_op   = 3'd0;
        rs_data = '0;
        rt_data = '0;
        shadow  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_pend", 64'(md_pending), 64'd0);

        // Test-plan vectors with hand-computed expectations.
        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, MD_NONE);
        check("mult_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, MD_NONE);
        check("multu_const", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, MD_NONE);
        check("div_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, MD_NONE);
        check("div_ovf_const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

        // Divide by zero leaves prior HI/LO in place.
        write_hilo("mthi11", MD_MTHI, 32'h11);
        write_hilo("mtlo22", MD_MTLO, 32'h22);
        run_op("divu0", MD_DIVU, 32'd100, 32'd0, 10, MD_NONE);
        check("divu0_const", {hi_out, lo_out}, 64'h0000_0011_0000_0022);

        write_hilo("mthi", MD_MTHI, 32'hDEAD_BEEF);
        check("mthi_const", 64'(hi_out), 64'hDEAD_BEEF);

        // Starts while busy are ignored: the running op finishes unchanged.
        run_op("mult_mtlo", MD_MULT, 32'd7, 32'd6, 5, MD_MTLO);
        check("mult_mtlo_const", {hi_out, lo_out}, 64'd42);
        run_op("div_mult", MD_DIVU, 32'd1000, 32'd7, 10, MD_MULT);

        // NONE and an undefined code do nothing.
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; rs_data = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        md_op = 3'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_hilo", {hi_out, lo_out}, shadow);

        // Random operations against the model.
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($signed(rb) == 0) rb = 32'd3;
            run_op("rand", rop, ra, rb, (rop >= 3'd3) ? 10 : 5, MD_NONE);
        end

        // Reset in the middle of a DIV aborts it; the quotient never appears.
        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; rs_data = 32'd9; rt_data = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        shadow = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || hi_out != 32'd0 || lo_out != 32'd0) cnt++;
        end
        check("abort_never_commit", 64'(cnt), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit beside the E-stage ALU of the 5-stage MIPS pipeline.
- Takes forwarded rs/rt operands from the Execute stage and owns the architectural HI/LO registers.
- Exposes busy/pending status to the stall/forward unit so mfhi/mflo/md-ops stall in D while an operation is in flight.
- HI/LO values feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an md-op; qualifies md_op.
- md_op  in  3  operation code (see package).
- rs_data  in  32  forwarded rs operand (E stage).
- rt_data  in  32  forwarded rt operand (E stage).
- busy  out  1  registered; operation in flight.
- md_pending  out  1  combinational: start | busy; drives D-stage stall for md-class instructions.
- hi_out  out  32  architectural HI register.
- lo_out  out  32  architectural LO register.

Behaviour:
- Reset (rising clk edge with reset=1): busy=0, counter=0, hi_out=0, lo_out=0, pending result regs=0.
  - Reset aborts any in-flight op; its result is never committed.
  - Reset dominates start.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}, at edge T:
  - Latch the computed result into pending_hi/pending_lo.
  - Load counter with N = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 after edge T.
- RUN: counter decrements each edge. At the edge where counter reaches 0 (edge T+N):
  - hi_out/lo_out <= pending values; busy=0; go to IDLE.
  - busy is therefore high for exactly N cycles; new HI/LO are visible the cycle busy falls.
- MTHI / MTLO with start=1 in IDLE: hi_out (resp. lo_out) <= rs_data at the next edge. busy stays 0.
- start=1 while busy=1: ignored; no state change. The stall unit guarantees this never happens; the bench checks it is harmless.
- start=1 with op NONE or an undefined code: ignored.
- MULT: {hi,lo} = signed(rs) * signed(rt), full 64-bit.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero (rt_data=0), DIV or DIVU: the unit still runs DIV_CYCLES with busy high, but hi_out/lo_out are left unchanged at completion.
- Outputs hi_out, lo_out, busy are registered. md_pending is the only combinational output.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default latency constants MULT_CYCLES=5, DIV_CYCLES=10.
  - The decoder in Decode/Execute imports the same package.
- One sub-module, mdu_arith: purely combinational signed/unsigned mult/div producing {hi,lo} and a div_by_zero flag.
- The top module holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi_out=0x00000001, lo_out=0xFFFFFFFE. md_pending=1 in the start cycle and all busy cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo remain 0x11/0x22.
- MTHI rs=0xDEADBEEF in IDLE -> hi_out=0xDEADBEEF next cycle, busy stays 0. MTLO issued during a running MULT -> ignored; the MULT result commits normally.
- Start DIV (rs=9, rt=3), assert reset at cycle 4 -> busy=0, hi=lo=0 the next cycle; the quotient 3 never appears.
